// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers op/a/b, S2 registers result and flags.
// Optional feature: define ALU_PIPE_SLT_EN to make op 011 a signed set-less-than (otherwise XOR).
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_XOR  = 3'b010,
      OP_SLT  = 3'b011,
      OP_AND  = 3'b100,
      OP_NAND = 3'b101,
      OP_NOR  = 3'b110,
      OP_OR   = 3'b111
   } op_t;

   logic             s1_valid;
   op_t              s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   logic             s1_adv;
   logic             s2_adv;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic             add_ovf;
   logic             sub_ovf;

   logic [WIDTH-1:0] nxt_result;
   logic             nxt_carry;
   logic             nxt_ovf;

   // A stage may load when it is empty or its contents leave in the same cycle.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = !reset && s1_adv;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_adv && in_valid) begin
         s1_op <= op_t'(op);
         s1_a  <= a;
         s1_b  <= b;
      end
   end

   assign add_sum = {1'b0, s1_a} + {1'b0, s1_b};
   assign sub_sum = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH+1)'(1);
   assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_sum[WIDTH-1] != s1_a[WIDTH-1]);
   assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_sum[WIDTH-1] != s1_a[WIDTH-1]);

   always_comb begin
      nxt_result = '0;
      nxt_carry  = 1'b0;
      nxt_ovf    = 1'b0;
      case (s1_op)
         OP_ADD: begin
            nxt_result = add_sum[WIDTH-1:0];
            nxt_carry  = add_sum[WIDTH];
            nxt_ovf    = add_ovf;
         end
         OP_SUB: begin
            nxt_result = sub_sum[WIDTH-1:0];
            nxt_carry  = sub_sum[WIDTH];
            nxt_ovf    = sub_ovf;
         end
`ifdef ALU_PIPE_SLT_EN
         OP_XOR: nxt_result = s1_a ^ s1_b;
         // Signed less-than is the sign of a-b corrected for overflow.
         OP_SLT: begin
            nxt_result = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
            nxt_carry  = sub_sum[WIDTH];
            nxt_ovf    = sub_ovf;
         end
`else
         OP_XOR, OP_SLT: nxt_result = s1_a ^ s1_b;
`endif
         OP_AND:  nxt_result = s1_a & s1_b;
         OP_NAND: nxt_result = ~(s1_a & s1_b);
         OP_NOR:  nxt_result = ~(s1_a | s1_b);
         OP_OR:   nxt_result = s1_a | s1_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= nxt_result;
            carry  <= nxt_carry;
            ovf    <= nxt_ovf;
            zero   <= (nxt_result == '0);
            neg    <= nxt_result[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed WIDTH=8 scenarios plus a WIDTH=32 random run
// against an arithmetic reference model. Honours ALU_PIPE_SLT_EN for op 011.
module tb_alu_pipe;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
   logic [2:0] n_op;
   logic [7:0] n_a, n_b, n_result;
   logic       n_carry, n_ovf, n_zero, n_neg;

   logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
   logic [2:0]  w_op;
   logic [31:0] w_a, w_b, w_result;
   logic        w_carry, w_ovf, w_zero, w_neg;

   int n_checks = 0;
   int n_fail = 0;

   alu_pipe #(.WIDTH(8)) u_narrow (
      .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
      .op(n_op), .a(n_a), .b(n_b), .out_valid(n_out_valid), .out_ready(n_out_ready),
      .result(n_result), .carry(n_carry), .ovf(n_ovf), .zero(n_zero), .neg(n_neg)
   );

   alu_pipe #(.WIDTH(32)) u_wide (
      .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .op(w_op), .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .result(w_result), .carry(w_carry), .ovf(w_ovf), .zero(w_zero), .neg(w_neg)
   );

   typedef struct {
      logic [63:0] res;
      bit          c;
      bit          v;
      bit          z;
      bit          n;
   } exp_t;

   function automatic longint sgn(longint unsigned v, int w);
      if (v[w-1]) return longint'(v) - (longint'(1) << w);
      return longint'(v);
   endfunction

   // Reference behaviour from plain integer arithmetic on w-bit values.
   function automatic exp_t model(int w, logic [2:0] op, longint unsigned a, longint unsigned b);
      exp_t e;
      longint unsigned mask = (64'd1 << w) - 1;
      longint unsigned full;
      longint sa = sgn(a, w);
      longint sb = sgn(b, w);
      longint lo = -(longint'(1) << (w - 1));
      longint hi = (longint'(1) << (w - 1)) - 1;
      e.res = 0; e.c = 0; e.v = 0;
      case (op)
         3'd0: begin
            full = a + b;
            e.res = full & mask;
            e.c = full[w];
            e.v = ((sa + sb) < lo) || ((sa + sb) > hi);
         end
         3'd1: begin
            full = a + ((~b) & mask) + 1;
            e.res = full & mask;
            e.c = full[w];
            e.v = ((sa - sb) < lo) || ((sa - sb) > hi);
         end
         3'd2: e.res = a ^ b;
         3'd3: begin
`ifdef ALU_PIPE_SLT_EN
            full = a + ((~b) & mask) + 1;
            e.c = full[w];
            e.v = ((sa - sb) < lo) || ((sa - sb) > hi);
            e.res = (sa < sb) ? 64'd1 : 64'd0;
`else
            e.res = a ^ b;
`endif
         end
         3'd4: e.res = a & b;
         3'd5: e.res = (~(a & b)) & mask;
         3'd6: e.res = (~(a | b)) & mask;
         default: e.res = a | b;
      endcase
      e.z = (e.res == 0);
      e.n = e.res[w-1];
      return e;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // One op on the narrow instance with out_ready high; returns #1 after the result lands.
   task automatic issue_narrow(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      n_in_valid = 1'b1; n_op = op; n_a = a; n_b = b;
      @(posedge clk); #1;
      n_in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      n_in_valid = 0; n_op = 0; n_a = 0; n_b = 0; n_out_ready = 1;
      w_in_valid = 0; w_op = 0; w_a = 0; w_b = 0; w_out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (n_in_ready !== 1'b0) begin
         n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 0", n_in_ready);
      end
      n_checks++;
      if ({n_out_valid, n_result, n_carry, n_ovf, n_zero, n_neg} !== 13'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got v=%b r=%h c=%b o=%b z=%b n=%b want all 0",
                  n_out_valid, n_result, n_carry, n_ovf, n_zero, n_neg);
      end
      n_checks++;
      if ({w_in_ready, w_out_valid, w_result} !== 34'd0) begin
         n_fail++; $display("[TB] FAIL reset_wide: got rdy=%b v=%b r=%h want 0", w_in_ready, w_out_valid, w_result);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (n_in_ready !== 1'b1 || w_in_ready !== 1'b1) begin
         n_fail++; $display("[TB] FAIL ready_after_reset: got %b/%b want 1/1", n_in_ready, w_in_ready);
      end
   endtask

   task automatic test_arith();
      @(negedge clk);
      n_in_valid = 1'b1; n_op = 3'd0; n_a = 8'hFF; n_b = 8'h01;
      @(posedge clk); #1;
      n_in_valid = 1'b0;
      n_checks++;
      if (n_out_valid !== 1'b0) begin
         n_fail++; $display("[TB] FAIL latency_early: out_valid got %b want 0 one cycle after accept", n_out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({n_out_valid, n_result, n_carry, n_ovf, n_zero, n_neg} !== {1'b1, 8'h00, 4'b1010}) begin
         n_fail++;
         $display("[TB] FAIL add_ff_01: got v=%b r=%h c=%b o=%b z=%b n=%b want v=1 r=00 c=1 o=0 z=1 n=0",
                  n_out_valid, n_result, n_carry, n_ovf, n_zero, n_neg);
      end
      issue_narrow(3'd0, 8'h7F, 8'h01);
      n_checks++;
      if ({n_out_valid, n_result, n_carry, n_ovf, n_zero, n_neg} !== {1'b1, 8'h80, 4'b0101}) begin
         n_fail++;
         $display("[TB] FAIL add_7f_01: got v=%b r=%h c=%b o=%b z=%b n=%b want v=1 r=80 c=0 o=1 z=0 n=1",
                  n_out_valid, n_result, n_carry, n_ovf, n_zero, n_neg);
      end
      issue_narrow(3'd1, 8'h05, 8'h05);
      n_checks++;
      if ({n_out_valid, n_result, n_carry, n_ovf, n_zero, n_neg} !== {1'b1, 8'h00, 4'b1010}) begin
         n_fail++;
         $display("[TB] FAIL sub_05_05: got v=%b r=%h c=%b o=%b z=%b n=%b want v=1 r=00 c=1 o=0 z=1 n=0",
                  n_out_valid, n_result, n_carry, n_ovf, n_zero, n_neg);
      end
   endtask

   task automatic test_slt();
      logic [11:0] want;
`ifdef ALU_PIPE_SLT_EN
      want = {8'h01, 4'b1000};
`else
      want = {8'hFF, 4'b0001};
`endif
      issue_narrow(3'd3, 8'hFE, 8'h01);
      n_checks++;
      if ({n_result, n_carry, n_ovf, n_zero, n_neg} !== want) begin
         n_fail++;
         $display("[TB] FAIL op011_fe_01: got r=%h c=%b o=%b z=%b n=%b want r=%h cozn=%b",
                  n_result, n_carry, n_ovf, n_zero, n_neg, want[11:4], want[3:0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] bop[3];
      logic [7:0] ba[3], bb[3], bexp[3];
      logic       bzero[3];
      int idx = 0;
      bop = '{3'd5, 3'd6, 3'd7};
      ba = '{8'hF0, 8'h0F, 8'h00};
      bb = '{8'hFF, 8'hF0, 8'h00};
      bexp = '{8'h0F, 8'h00, 8'h00};
      bzero = '{1'b0, 1'b1, 1'b1};
      @(posedge clk);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_out_ready = 1'b0;
         n_in_valid = 1'b1;
         n_op = bop[idx]; n_a = ba[idx]; n_b = bb[idx];
         #1;
         if (c >= 2) begin
            n_checks++;
            if (n_in_ready !== 1'b0 || n_out_valid !== 1'b1 || n_result !== 8'h0F) begin
               n_fail++;
               $display("[TB] FAIL stall_cycle%0d: got rdy=%b v=%b r=%h want rdy=0 v=1 r=0f",
                        c, n_in_ready, n_out_valid, n_result);
            end
         end
         if (n_in_ready === 1'b1) idx++;
      end
      n_checks++;
      if (idx != 2) begin
         n_fail++; $display("[TB] FAIL stall_accepts: got %0d want 2", idx);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_out_ready = 1'b1;
         n_in_valid = (idx < 3);
         if (idx < 3) begin
            n_op = bop[idx]; n_a = ba[idx]; n_b = bb[idx];
         end
         #1;
         n_checks++;
         if ({n_out_valid, n_result, n_zero} !== {1'b1, bexp[k], bzero[k]}) begin
            n_fail++;
            $display("[TB] FAIL drain_%0d: got v=%b r=%h z=%b want v=1 r=%h z=%b",
                     k, n_out_valid, n_result, n_zero, bexp[k], bzero[k]);
         end
         if (n_in_valid && n_in_ready) idx++;
      end
      @(negedge clk);
      n_in_valid = 1'b0;
      #1;
      n_checks++;
      if (n_out_valid !== 1'b0 || idx != 3) begin
         n_fail++; $display("[TB] FAIL drain_end: got v=%b accepted=%0d want v=0 accepted=3", n_out_valid, idx);
      end
   endtask

   task automatic test_reset_flush();
      @(negedge clk);
      n_out_ready = 1'b0;
      n_in_valid = 1'b1; n_op = 3'd0; n_a = 8'h01; n_b = 8'h02;
      @(posedge clk);
      @(negedge clk);
      n_a = 8'h03; n_b = 8'h04;
      @(posedge clk);
      @(negedge clk);
      n_in_valid = 1'b0;
      #1;
      n_checks++;
      if (n_out_valid !== 1'b1 || n_in_ready !== 1'b0) begin
         n_fail++; $display("[TB] FAIL full_pipe: got v=%b rdy=%b want v=1 rdy=0", n_out_valid, n_in_ready);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (n_out_valid !== 1'b0 || n_result !== 8'h00) begin
         n_fail++; $display("[TB] FAIL flush_reset: got v=%b r=%h want v=0 r=00", n_out_valid, n_result);
      end
      @(negedge clk);
      reset = 1'b0;
      n_out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         n_checks++;
         if (n_out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL stale_after_reset_%0d: out_valid got %b want 0", c, n_out_valid);
         end
      end
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      int accepted = 0;
      int cycles = 0;
      bit stall = 0;
      logic [31:0] h_res;
      logic [3:0]  h_fl;
      while ((accepted < 1000 || q.size() > 0) && cycles < 20000) begin
         @(negedge clk);
         w_in_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
         w_op = 3'($urandom_range(0, 7));
         w_a = rand_operand();
         w_b = rand_operand();
         w_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (stall) begin
            n_checks++;
            if (w_out_valid !== 1'b1 || w_result !== h_res || {w_carry, w_ovf, w_zero, w_neg} !== h_fl) begin
               n_fail++;
               $display("[TB] FAIL hold_stable: got v=%b r=%h f=%b want v=1 r=%h f=%b",
                        w_out_valid, w_result, {w_carry, w_ovf, w_zero, w_neg}, h_res, h_fl);
            end
         end
         if (w_out_valid === 1'b1 && w_out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("[TB] FAIL spurious_output: got r=%h with nothing outstanding", w_result);
            end else begin
               e = q.pop_front();
               if (w_result !== e.res[31:0] || {w_carry, w_ovf, w_zero, w_neg} !== {e.c, e.v, e.z, e.n}) begin
                  n_fail++;
                  $display("[TB] FAIL random_result: got r=%h cozn=%b want r=%h cozn=%b",
                           w_result, {w_carry, w_ovf, w_zero, w_neg}, e.res[31:0], {e.c, e.v, e.z, e.n});
               end
            end
         end
         stall = (w_out_valid === 1'b1) && !w_out_ready;
         h_res = w_result;
         h_fl = {w_carry, w_ovf, w_zero, w_neg};
         if (w_in_valid && w_in_ready === 1'b1) begin
            q.push_back(model(32, w_op, 64'(w_a), 64'(w_b)));
            accepted++;
         end
         cycles++;
      end
      @(negedge clk);
      w_in_valid = 1'b0;
      n_checks++;
      if (accepted != 1000 || q.size() != 0) begin
         n_fail++; $display("[TB] FAIL random_complete: got accepted=%0d outstanding=%0d want 1000/0", accepted, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_slt();
      test_back_to_back();
      test_reset_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
